// File: rtl/aclk_ctrl_fsm.sv
// rtl/aclk_ctrl_fsm.sv - alarm clock keypad/button control FSM (Moore)
// Optional key-entry timeout built only when ACLK_CTRL_TIMEOUT_EN is defined.
module aclk_ctrl_fsm #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       alarm_button,
    input  logic       time_button,
    input  logic [3:0] key,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic       shift,
    output logic       load_alarm,
    output logic       load_time,
    output logic       reset_count
);

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_STORED,
        KEY_WAITED,
        KEY_ENTRY,
        SHOW_ALARM,
        SET_ALARM_TIME,
        SET_CURRENT_TIME
    } state_t;

    state_t state;
    state_t state_next;
    logic   is_digit;
    logic   timeout;

    assign is_digit = (key <= 4'd9);

`ifdef ACLK_CTRL_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_VAL = TIMEOUT_SEC[7:0];

    logic [7:0] timeout_cnt;

    // Counts only while waiting for keys; any other state (including
    // KEY_STORED) clears it, so every new digit restarts the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt <= 8'd0;
        end else if (state == KEY_WAITED || state == KEY_ENTRY) begin
            if (one_second && timeout_cnt < TIMEOUT_VAL) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
        end else begin
            timeout_cnt <= 8'd0;
        end
    end

    assign timeout = (timeout_cnt == TIMEOUT_VAL);
`else
    logic unused_one_second;

    assign unused_one_second = one_second;
    assign timeout           = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SHOW_TIME;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SHOW_TIME: begin
                if (alarm_button) begin
                    state_next = SHOW_ALARM;
                end else if (is_digit) begin
                    state_next = KEY_STORED;
                end
            end
            KEY_STORED: begin
                state_next = KEY_WAITED;
            end
            // A held key keeps us here, so it can never shift twice.
            KEY_WAITED: begin
                if (!is_digit) begin
                    state_next = KEY_ENTRY;
                end else if (timeout) begin
                    state_next = SHOW_TIME;
                end
            end
            KEY_ENTRY: begin
                if (alarm_button) begin
                    state_next = SET_ALARM_TIME;
                end else if (time_button) begin
                    state_next = SET_CURRENT_TIME;
                end else if (is_digit) begin
                    state_next = KEY_STORED;
                end else if (timeout) begin
                    state_next = SHOW_TIME;
                end
            end
            SHOW_ALARM: begin
                if (!alarm_button) begin
                    state_next = SHOW_TIME;
                end
            end
            SET_ALARM_TIME: begin
                state_next = SHOW_TIME;
            end
            SET_CURRENT_TIME: begin
                state_next = SHOW_TIME;
            end
            default: begin
                state_next = SHOW_TIME;
            end
        endcase
    end

    always_comb begin
        show_new_time = 1'b0;
        show_alarm    = 1'b0;
        shift         = 1'b0;
        load_alarm    = 1'b0;
        load_time     = 1'b0;
        reset_count   = 1'b0;
        case (state)
            KEY_STORED: begin
                show_new_time = 1'b1;
                shift         = 1'b1;
            end
            KEY_WAITED,
            KEY_ENTRY: begin
                show_new_time = 1'b1;
            end
            SHOW_ALARM: begin
                show_alarm = 1'b1;
            end
            SET_ALARM_TIME: begin
                load_alarm = 1'b1;
            end
            SET_CURRENT_TIME: begin
                load_time   = 1'b1;
                reset_count = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_aclk_ctrl_fsm.sv
// tb/tb_aclk_ctrl_fsm.sv - table-driven and directed checks for aclk_ctrl_fsm
module tb_aclk_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_second;
    logic       alarm_button;
    logic       time_button;
    logic [3:0] key;
    logic       show_new_time;
    logic       show_alarm;
    logic       shift;
    logic       load_alarm;
    logic       load_time;
    logic       reset_count;

    int checks = 0;
    int errors = 0;

    // Output vector order: {show_new_time, show_alarm, shift, load_alarm, load_time, reset_count}
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_STORE = 6'b101000;
    localparam logic [5:0] O_ENTRY = 6'b100000;
    localparam logic [5:0] O_ALARM = 6'b010000;
    localparam logic [5:0] O_LDALM = 6'b000100;
    localparam logic [5:0] O_LDTIM = 6'b000011;

    typedef struct {
        logic       alarm;
        logic       tbtn;
        logic [3:0] key;
        logic       sec;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    aclk_ctrl_fsm #(.TIMEOUT_SEC(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .one_second   (one_second),
        .alarm_button (alarm_button),
        .time_button  (time_button),
        .key          (key),
        .show_new_time(show_new_time),
        .show_alarm   (show_alarm),
        .shift        (shift),
        .load_alarm   (load_alarm),
        .load_time    (load_time),
        .reset_count  (reset_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {show_new_time, show_alarm, shift, load_alarm, load_time, reset_count};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic cyc(input logic a, input logic t, input logic [3:0] k, input logic s);
        alarm_button = a;
        time_button  = t;
        key          = k;
        one_second   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic a, input logic t, input logic [3:0] k, input logic s,
                       input logic [5:0] e, input string n);
        vec_t v;
        v.alarm = a; v.tbtn = t; v.key = k; v.sec = s; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic enter_digit(input logic [3:0] d, input string n);
        cyc(0, 0, d, 0);     check({n, "_store"}, O_STORE);
        cyc(0, 0, 4'd15, 0); check({n, "_wait"}, O_ENTRY);
        cyc(0, 0, 4'd15, 0); check({n, "_entry"}, O_ENTRY);
    endtask

    task automatic sec_pulse();
        cyc(0, 0, 4'd15, 1);
        cyc(0, 0, 4'd15, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_async", O_IDLE);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; one_second = 0; alarm_button = 0; time_button = 0; key = 4'd15;
        #2;
        check("reset_outputs", O_IDLE);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Held digit gives one shift; NOKEY moves to entry
        add(0, 0, 4'd5,  0, O_STORE, "k5_store");
        add(0, 0, 4'd5,  0, O_ENTRY, "k5_held1");
        add(0, 0, 4'd5,  0, O_ENTRY, "k5_held2");
        add(0, 0, 4'd5,  0, O_ENTRY, "k5_held3");
        add(0, 0, 4'd10, 0, O_ENTRY, "k5_release");
        add(0, 0, 4'd12, 0, O_ENTRY, "k5_entry_idle");
        // Four digits then commit time
        for (int d = 1; d <= 4; d++) begin
            add(0, 0, 4'(d),  0, O_STORE, $sformatf("d%0d_store", d));
            add(0, 0, 4'd15, 0, O_ENTRY, $sformatf("d%0d_wait", d));
            add(0, 0, 4'd15, 0, O_ENTRY, $sformatf("d%0d_entry", d));
        end
        add(0, 1, 4'd15, 0, O_LDTIM, "set_time");
        add(0, 0, 4'd15, 0, O_IDLE,  "after_set_time");
        add(0, 0, 4'd15, 0, O_IDLE,  "idle_show_time");
        // alarm wins over time in KEY_ENTRY
        add(0, 0, 4'd7,  0, O_STORE, "d7_store");
        add(0, 0, 4'd15, 0, O_ENTRY, "d7_wait");
        add(0, 0, 4'd15, 0, O_ENTRY, "d7_entry");
        add(1, 1, 4'd15, 0, O_LDALM, "alarm_over_time");
        add(0, 0, 4'd15, 0, O_IDLE,  "after_set_alarm");
        // time wins over digit in KEY_ENTRY
        add(0, 0, 4'd8,  0, O_STORE, "d8_store");
        add(0, 0, 4'd15, 0, O_ENTRY, "d8_wait");
        add(0, 0, 4'd15, 0, O_ENTRY, "d8_entry");
        add(0, 1, 4'd2,  0, O_LDTIM, "time_over_digit");
        add(0, 0, 4'd15, 0, O_IDLE,  "after_time2");
        // Alarm display with simultaneous digit
        for (int i = 0; i < 5; i++) add(1, 0, 4'd3, 0, O_ALARM, $sformatf("show_alarm%0d", i));
        add(0, 0, 4'd15, 0, O_IDLE, "alarm_release");
        add(0, 0, 4'd15, 0, O_IDLE, "alarm_idle");

        foreach (vecs[i]) begin
            cyc(vecs[i].alarm, vecs[i].tbtn, vecs[i].key, vecs[i].sec);
            check(vecs[i].name, vecs[i].exp);
        end

        // Timeout behaviour
        enter_digit(4'd1, "to");
`ifdef ACLK_CTRL_TIMEOUT_EN
        repeat (9) sec_pulse();
        check("to_after9", O_ENTRY);
        cyc(0, 0, 4'd15, 1); check("to_reached10", O_ENTRY);
        cyc(0, 0, 4'd15, 0); check("to_exit", O_IDLE);
        enter_digit(4'd2, "rs");
        repeat (9) sec_pulse();
        enter_digit(4'd3, "rs2");
        repeat (9) sec_pulse();
        check("rs_still_entry", O_ENTRY);
        sec_pulse();
        check("rs_exit", O_IDLE);
`else
        repeat (20) sec_pulse();
        check("no_to_entry", O_ENTRY);
        cyc(0, 0, 4'd9, 0); check("no_to_digit", O_STORE);
        cyc(0, 0, 4'd15, 0);
        cyc(0, 0, 4'd15, 0);
        cyc(0, 1, 4'd15, 0); check("no_to_set", O_LDTIM);
        cyc(0, 0, 4'd15, 0); check("no_to_idle", O_IDLE);
`endif

        // Reset in SET_CURRENT_TIME
        enter_digit(4'd6, "rst_a");
        cyc(0, 1, 4'd15, 0); check("rst_a_load", O_LDTIM);
        time_button = 1'b0;
        do_reset();
        cyc(0, 0, 4'd15, 0); check("rst_a_after", O_IDLE);

        // Reset in KEY_WAITED with a held key and ticking seconds
        cyc(0, 0, 4'd6, 0); check("rst_b_store", O_STORE);
        cyc(0, 0, 4'd6, 1); check("rst_b_wait", O_ENTRY);
        cyc(0, 0, 4'd6, 1); check("rst_b_wait2", O_ENTRY);
        cyc(0, 0, 4'd6, 1);
        time_button = 1'b1;
        key = 4'd15;
        do_reset();
`ifdef ACLK_CTRL_TIMEOUT_EN
        checks++;
        if (dut.timeout_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_b_cnt: got %0d expected 0", dut.timeout_cnt);
        end
`endif
        cyc(0, 1, 4'd15, 0); check("rst_b_no_load", O_IDLE);
        cyc(0, 0, 4'd4, 0);  check("rst_b_first_shift", O_STORE);
        cyc(0, 0, 4'd4, 0);  check("rst_b_wait_again", O_ENTRY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
